// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
// Holds CSR addresses, mstatus/mie bit positions, interrupt cause codes, the
// sequencer state enum, and helpers that build the mstatus values written on
// trap entry and mret.
package csr_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  localparam int unsigned MstatusMie   = 3;
  localparam int unsigned MstatusMpie  = 7;
  localparam int unsigned MstatusMppLo = 11;
  localparam int unsigned MstatusMppHi = 12;

  localparam int unsigned MieMtie = 7;
  localparam int unsigned MieMeie = 11;

  localparam logic [31:0] CauseMExt   = 32'h8000_000B;
  localparam logic [31:0] CauseMTimer = 32'h8000_0007;

  typedef enum logic [2:0] {
    StIdle,
    StSaveEpc,
    StSaveCause,
    StUpdStatus,
    StMretStatus,
    StWfiSleep,
    StRedirect
  } trap_state_e;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] mstatus);
    logic [31:0] res;
    res                            = mstatus;
    res[MstatusMpie]               = mstatus[MstatusMie];
    res[MstatusMie]                = 1'b0;
    res[MstatusMppHi:MstatusMppLo] = 2'b11;
    return res;
  endfunction

  // mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] mstatus);
    logic [31:0] res;
    res                            = mstatus;
    res[MstatusMie]                = mstatus[MstatusMpie];
    res[MstatusMpie]               = 1'b1;
    res[MstatusMppHi:MstatusMppLo] = 2'b11;
    return res;
  endfunction

endpackage

// File: rtl/csr_wport_mux.sv
// CSR write-port arbiter between the pipeline and the trap sequencer.
// Ports:
//   sel_fsm               - 1 selects the sequencer source, 0 the pipeline
//   fsm_we/waddr/wdata    - sequencer write source
//   pipe_we/waddr/wdata   - pipeline write source
//   csr_we/waddr/wdata    - the single CSR write port
// Address and data are forced to zero when no write is issued.
module csr_wport_mux #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  sel_fsm,
  input  logic                  fsm_we,
  input  logic [ADDR_WIDTH-1:0] fsm_waddr,
  input  logic [DATA_WIDTH-1:0] fsm_wdata,
  input  logic                  pipe_we,
  input  logic [ADDR_WIDTH-1:0] pipe_waddr,
  input  logic [DATA_WIDTH-1:0] pipe_wdata,
  output logic                  csr_we,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata
);

  always_comb begin
    csr_we    = 1'b0;
    csr_waddr = '0;
    csr_wdata = '0;
    if (sel_fsm) begin
      if (fsm_we) begin
        csr_we    = 1'b1;
        csr_waddr = fsm_waddr;
        csr_wdata = fsm_wdata;
      end
    end else if (pipe_we) begin
      csr_we    = 1'b1;
      csr_waddr = pipe_waddr;
      csr_wdata = pipe_wdata;
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/interrupt sequencer owning the single CSR write port.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   csr_req_*                  - pipeline CSR write request / accept
//   ext_irq, timer_irq         - interrupt levels
//   mret_valid, wfi_valid      - mret / wfi in EX; ex_pc is its PC
//   mstatus_q..mepc_q          - current CSR values
//   csr_we/waddr/wdata         - CSR write port
//   stall                      - freeze IF/ID/EX
//   redirect_valid/pc          - one-cycle PC redirect
// Trap entry writes mepc, mcause, mstatus on consecutive cycles then redirects
// to mtvec; mret writes mstatus then redirects to mepc.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_req_valid,
  input  logic [ADDR_WIDTH-1:0] csr_req_addr,
  input  logic [DATA_WIDTH-1:0] csr_req_wdata,
  output logic                  csr_req_ready,
  input  logic                  ext_irq,
  input  logic                  timer_irq,
  input  logic                  mret_valid,
  input  logic                  wfi_valid,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] mstatus_q,
  input  logic [DATA_WIDTH-1:0] mie_q,
  input  logic [DATA_WIDTH-1:0] mtvec_q,
  input  logic [DATA_WIDTH-1:0] mepc_q,
  output logic                  csr_we,
  output logic [ADDR_WIDTH-1:0] csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  stall,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  trap_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] epc_q, epc_d;
  logic [DATA_WIDTH-1:0] cause_q, cause_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;

  logic                  en_ext, en_tmr, any_irq, take;
  logic [DATA_WIDTH-1:0] cause_sel;

  logic                  sel_fsm, fsm_we, pipe_we, stall_raw;
  logic [ADDR_WIDTH-1:0] fsm_waddr;
  logic [DATA_WIDTH-1:0] fsm_wdata;

  logic unused_bits;
  assign unused_bits = ^{mie_q[DATA_WIDTH-1:12], mie_q[10:8], mie_q[6:0], mtvec_q[1:0]};

  assign en_ext    = ext_irq & mie_q[MieMeie];
  assign en_tmr    = timer_irq & mie_q[MieMtie];
  assign any_irq   = en_ext | en_tmr;
  assign take      = mstatus_q[MstatusMie] & any_irq;
  assign cause_sel = en_ext ? CauseMExt : CauseMTimer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (take) begin
          epc_d   = ex_pc;
          cause_d = cause_sel;
          state_d = StSaveEpc;
        end else if (mret_valid) begin
          state_d = StMretStatus;
        end else if (wfi_valid) begin
          state_d = StWfiSleep;
        end
      end
      StSaveEpc:   state_d = StSaveCause;
      StSaveCause: state_d = StUpdStatus;
      StUpdStatus: begin
        target_d = {mtvec_q[DATA_WIDTH-1:2], 2'b00};
        state_d  = StRedirect;
      end
      StMretStatus: begin
        target_d = mepc_q;
        state_d  = StRedirect;
      end
      StWfiSleep: begin
        // Wake ignores MIE; MIE only decides whether the wake becomes a trap.
        if (any_irq) begin
          if (mstatus_q[MstatusMie]) begin
            epc_d   = ex_pc + DATA_WIDTH'(4);
            cause_d = cause_sel;
            state_d = StSaveEpc;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    sel_fsm        = 1'b0;
    fsm_we         = 1'b0;
    fsm_waddr      = '0;
    fsm_wdata      = '0;
    stall_raw      = 1'b1;
    csr_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StIdle: begin
        if (!(take || mret_valid || wfi_valid)) begin
          stall_raw     = 1'b0;
          csr_req_ready = 1'b1;
        end
      end
      StSaveEpc: begin
        sel_fsm   = 1'b1;
        fsm_we    = 1'b1;
        fsm_waddr = CsrMepc;
        fsm_wdata = epc_q;
      end
      StSaveCause: begin
        sel_fsm   = 1'b1;
        fsm_we    = 1'b1;
        fsm_waddr = CsrMcause;
        fsm_wdata = cause_q;
      end
      StUpdStatus: begin
        sel_fsm   = 1'b1;
        fsm_we    = 1'b1;
        fsm_waddr = CsrMstatus;
        fsm_wdata = trap_mstatus(mstatus_q);
      end
      StMretStatus: begin
        sel_fsm   = 1'b1;
        fsm_we    = 1'b1;
        fsm_waddr = CsrMstatus;
        fsm_wdata = mret_mstatus(mstatus_q);
      end
      StWfiSleep: ;
      StRedirect: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
      end
      default: ;
    endcase
  end

  // While rst is held the state is already IDLE; only ready stays live.
  assign stall   = stall_raw & ~rst;
  assign pipe_we = csr_req_valid & csr_req_ready & ~rst;

  csr_wport_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_wport_mux (
    .sel_fsm   (sel_fsm),
    .fsm_we    (fsm_we),
    .fsm_waddr (fsm_waddr),
    .fsm_wdata (fsm_wdata),
    .pipe_we   (pipe_we),
    .pipe_waddr(csr_req_addr),
    .pipe_wdata(csr_req_wdata),
    .csr_we    (csr_we),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata)
  );

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: IDLE decode vectors from a table,
// then hand-written trap, mret, wfi and mid-sequence reset sequences.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req_valid;
  logic [11:0] csr_req_addr;
  logic [31:0] csr_req_wdata;
  logic        csr_req_ready;
  logic        ext_irq, timer_irq, mret_valid, wfi_valid;
  logic [31:0] ex_pc, mstatus_q, mie_q, mtvec_q, mepc_q;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall, redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  csr_trap_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .csr_req_valid (csr_req_valid),
    .csr_req_addr  (csr_req_addr),
    .csr_req_wdata (csr_req_wdata),
    .csr_req_ready (csr_req_ready),
    .ext_irq       (ext_irq),
    .timer_irq     (timer_irq),
    .mret_valid    (mret_valid),
    .wfi_valid     (wfi_valid),
    .ex_pc         (ex_pc),
    .mstatus_q     (mstatus_q),
    .mie_q         (mie_q),
    .mtvec_q       (mtvec_q),
    .mepc_q        (mepc_q),
    .csr_we        (csr_we),
    .csr_waddr     (csr_waddr),
    .csr_wdata     (csr_wdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req_v;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        ext;
    logic        tmr;
    logic        mret;
    logic        wfi;
    logic [31:0] mst;
    logic [31:0] mie;
    logic        e_ready;
    logic        e_we;
    logic [11:0] e_addr;
    logic [31:0] e_wd;
    logic        e_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic quiet();
    csr_req_valid = 1'b0;
    csr_req_addr  = '0;
    csr_req_wdata = '0;
    ext_irq       = 1'b0;
    timer_irq     = 1'b0;
    mret_valid    = 1'b0;
    wfi_valid     = 1'b0;
  endtask

  task automatic chk_write(input string name, input logic [11:0] a, input logic [31:0] d);
    check({name, " we"}, {31'd0, csr_we}, 32'd1);
    check({name, " addr"}, {20'd0, csr_waddr}, {20'd0, a});
    check({name, " data"}, csr_wdata, d);
    check({name, " stall"}, {31'd0, stall}, 32'd1);
  endtask

  task automatic chk_redirect(input string name, input logic [31:0] pc);
    check({name, " rv"}, {31'd0, redirect_valid}, 32'd1);
    check({name, " pc"}, redirect_pc, pc);
    check({name, " stall"}, {31'd0, stall}, 32'd1);
    check({name, " we"}, {31'd0, csr_we}, 32'd0);
  endtask

  task automatic chk_idle(input string name);
    check({name, " stall"}, {31'd0, stall}, 32'd0);
    check({name, " rv"}, {31'd0, redirect_valid}, 32'd0);
    check({name, " ready"}, {31'd0, csr_req_ready}, 32'd1);
  endtask

  initial begin
    quiet();
    ex_pc = '0; mstatus_q = '0; mie_q = '0; mtvec_q = '0; mepc_q = '0;
    rst = 1'b1;
    #1;
    check("reset we", {31'd0, csr_we}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset rv", {31'd0, redirect_valid}, 32'd0);
    check("reset rpc", redirect_pc, 32'd0);
    check("reset ready", {31'd0, csr_req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // req_v addr wd ext tmr mret wfi mst mie | ready we addr wd stall
    vecs[0] = '{1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b1, 1'b0, 12'h000, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 12'h300, 32'hA, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1800, 32'h800,
                1'b1, 1'b1, 12'h300, 32'hA, 1'b0};
    vecs[2] = '{1'b1, 12'h305, 32'h7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h800,
                1'b0, 1'b0, 12'h000, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 12'h341, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 12'h000, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 12'h342, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0,
                1'b0, 1'b0, 12'h000, 32'h0, 1'b1};
    vecs[5] = '{1'b1, 12'h305, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h800,
                1'b1, 1'b1, 12'h305, 32'h55, 1'b0};
    vecs[6] = '{1'b1, 12'h304, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h80,
                1'b1, 1'b1, 12'h304, 32'hFFFF_FFFF, 1'b0};
    vecs[7] = '{1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0,
                1'b0, 1'b0, 12'h000, 32'h0, 1'b1};
    vecs[8] = '{1'b1, 12'h300, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8, 32'h80,
                1'b0, 1'b0, 12'h000, 32'h0, 1'b1};
    vecs[9] = '{1'b0, 12'h300, 32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h880,
                1'b1, 1'b0, 12'h000, 32'h0, 1'b0};

    // Each vector is removed before the next rising edge, so state stays IDLE.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      csr_req_valid = vecs[i].req_v;
      csr_req_addr  = vecs[i].addr;
      csr_req_wdata = vecs[i].wd;
      ext_irq       = vecs[i].ext;
      timer_irq     = vecs[i].tmr;
      mret_valid    = vecs[i].mret;
      wfi_valid     = vecs[i].wfi;
      mstatus_q     = vecs[i].mst;
      mie_q         = vecs[i].mie;
      #1;
      check($sformatf("vec%0d ready", i), {31'd0, csr_req_ready}, {31'd0, vecs[i].e_ready});
      check($sformatf("vec%0d we", i), {31'd0, csr_we}, {31'd0, vecs[i].e_we});
      check($sformatf("vec%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      if (vecs[i].e_we) begin
        check($sformatf("vec%0d addr", i), {20'd0, csr_waddr}, {20'd0, vecs[i].e_addr});
        check($sformatf("vec%0d data", i), csr_wdata, vecs[i].e_wd);
      end
      #1;
      quiet();
    end

    // External interrupt trap entry.
    mstatus_q = 32'h1808; mie_q = 32'h800; mtvec_q = 32'h200; ex_pc = 32'h100;
    @(negedge clk);
    ext_irq = 1'b1; csr_req_valid = 1'b1; csr_req_addr = 12'h305; csr_req_wdata = 32'h7;
    #1;
    check("trap accept stall", {31'd0, stall}, 32'd1);
    check("trap accept ready", {31'd0, csr_req_ready}, 32'd0);
    check("trap accept we", {31'd0, csr_we}, 32'd0);
    @(negedge clk); quiet(); #1; chk_write("trap mepc", 12'h341, 32'h100);
    @(negedge clk); #1; chk_write("trap mcause", 12'h342, 32'h8000_000B);
    @(negedge clk); #1; chk_write("trap mstatus", 12'h300, 32'h1880);
    @(negedge clk); #1; chk_redirect("trap redirect", 32'h200);
    @(negedge clk); #1; chk_idle("trap done");

    // Both interrupts pending: external wins; mtvec low bits masked.
    mie_q = 32'h880; mtvec_q = 32'h202; ex_pc = 32'h180;
    @(negedge clk);
    ext_irq = 1'b1; timer_irq = 1'b1;
    #1; check("both accept stall", {31'd0, stall}, 32'd1);
    @(negedge clk); quiet(); #1; chk_write("both mepc", 12'h341, 32'h180);
    @(negedge clk); #1; chk_write("both mcause", 12'h342, 32'h8000_000B);
    @(negedge clk); #1; chk_write("both mstatus", 12'h300, 32'h1880);
    @(negedge clk); #1; chk_redirect("both redirect", 32'h200);
    @(negedge clk); #1; chk_idle("both done");

    // mret.
    mstatus_q = 32'h1880; mepc_q = 32'h104;
    @(negedge clk);
    mret_valid = 1'b1;
    #1;
    check("mret accept stall", {31'd0, stall}, 32'd1);
    check("mret accept we", {31'd0, csr_we}, 32'd0);
    @(negedge clk); quiet(); #1; chk_write("mret mstatus", 12'h300, 32'h1888);
    @(negedge clk); #1; chk_redirect("mret redirect", 32'h104);
    @(negedge clk); #1; chk_idle("mret done");

    // wfi with MIE=1, timer wake after 10 cycles.
    mstatus_q = 32'h1808; mie_q = 32'h80; ex_pc = 32'h300; mtvec_q = 32'h400;
    @(negedge clk);
    wfi_valid = 1'b1;
    #1; check("wfi accept stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); quiet(); #1;
      check("wfi sleep stall", {31'd0, stall}, 32'd1);
      check("wfi sleep we", {31'd0, csr_we}, 32'd0);
    end
    @(negedge clk); timer_irq = 1'b1; #1;
    check("wfi wake stall", {31'd0, stall}, 32'd1);
    check("wfi wake we", {31'd0, csr_we}, 32'd0);
    @(negedge clk); quiet(); #1; chk_write("wfi mepc", 12'h341, 32'h304);
    @(negedge clk); #1; chk_write("wfi mcause", 12'h342, 32'h8000_0007);
    @(negedge clk); #1; chk_write("wfi mstatus", 12'h300, 32'h1880);
    @(negedge clk); #1; chk_redirect("wfi redirect", 32'h400);
    @(negedge clk); #1; chk_idle("wfi done");

    // wfi at the top of the address space: epc wraps to zero.
    mie_q = 32'h800; ex_pc = 32'hFFFF_FFFC;
    @(negedge clk); wfi_valid = 1'b1;
    @(negedge clk); quiet(); ext_irq = 1'b1; #1;
    check("wrap wake stall", {31'd0, stall}, 32'd1);
    @(negedge clk); quiet(); #1; chk_write("wrap mepc", 12'h341, 32'h0);
    @(negedge clk); #1; chk_write("wrap mcause", 12'h342, 32'h8000_000B);
    @(negedge clk); #1; chk_write("wrap mstatus", 12'h300, 32'h1880);
    @(negedge clk); #1; chk_redirect("wrap redirect", 32'h400);
    @(negedge clk); #1; chk_idle("wrap done");

    // wfi with MIE=0: wake without trap or redirect.
    mstatus_q = 32'h1800; mie_q = 32'h80; ex_pc = 32'h300;
    @(negedge clk); wfi_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); quiet(); #1;
      check("wfi0 sleep stall", {31'd0, stall}, 32'd1);
    end
    @(negedge clk); timer_irq = 1'b1; #1;
    check("wfi0 wake stall", {31'd0, stall}, 32'd1);
    check("wfi0 wake we", {31'd0, csr_we}, 32'd0);
    @(negedge clk); #1;
    chk_idle("wfi0 after");
    check("wfi0 after we", {31'd0, csr_we}, 32'd0);
    @(negedge clk); #1;
    check("wfi0 later we", {31'd0, csr_we}, 32'd0);
    check("wfi0 later rv", {31'd0, redirect_valid}, 32'd0);
    quiet();

    // Reset in the middle of SAVE_CAUSE.
    mstatus_q = 32'h1808; mie_q = 32'h800; ex_pc = 32'h100; mtvec_q = 32'h200;
    @(negedge clk); ext_irq = 1'b1;
    @(negedge clk); quiet();
    @(negedge clk); #1; chk_write("rst pre mcause", 12'h342, 32'h8000_000B);
    rst = 1'b1;
    #1;
    check("rst mid we", {31'd0, csr_we}, 32'd0);
    check("rst mid stall", {31'd0, stall}, 32'd0);
    check("rst mid rv", {31'd0, redirect_valid}, 32'd0);
    check("rst mid rpc", redirect_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    csr_req_valid = 1'b1; csr_req_addr = 12'h304; csr_req_wdata = 32'h880;
    #1;
    check("rst after ready", {31'd0, csr_req_ready}, 32'd1);
    check("rst after we", {31'd0, csr_we}, 32'd1);
    check("rst after addr", {20'd0, csr_waddr}, 32'h304);
    check("rst after data", csr_wdata, 32'h880);
    check("rst after stall", {31'd0, stall}, 32'd0);
    @(negedge clk); quiet(); #1;
    chk_idle("rst settled");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
- Machine-mode trap/interrupt sequencer that owns the single CSR write port.
- Shares the write port between pipeline CSR instructions and its own trap-entry, mret and wfi sequences.
- Sits beside the CSR unit. Stalls the pipeline and issues a PC redirect when a trap is taken or a return completes.
- One CSR write per cycle; trap entry writes mepc, mcause and mstatus in a fixed order.

Parameters:
DATA_WIDTH, 32, CSR data / PC width
ADDR_WIDTH, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
csr_req_valid  in  1  pipeline CSR write request
csr_req_addr  in  12  pipeline CSR write address
csr_req_wdata  in  32  pipeline CSR write data, already combined with rs1/imm by the op
csr_req_ready  out  1  pipeline request accepted this cycle
ext_irq  in  1  external interrupt level
timer_irq  in  1  timer interrupt level
mret_valid  in  1  mret in EX
wfi_valid  in  1  wfi in EX
ex_pc  in  32  PC of the EX instruction
mstatus_q  in  32  current mstatus
mie_q  in  32  current mie; bit 11 is MEIE, bit 7 is MTIE
mtvec_q  in  32  current mtvec, direct mode only
mepc_q  in  32  current mepc
csr_we  out  1  CSR write enable
csr_waddr  out  12  CSR write address
csr_wdata  out  32  CSR write data
stall  out  1  freeze IF/ID/EX
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  32  redirect target

Behaviour:
- States: IDLE, SAVE_EPC, SAVE_CAUSE, UPD_STATUS, MRET_STATUS, WFI_SLEEP, REDIRECT.
- Reset (asynchronous, mid-operation included): state IDLE, latched epc/cause/target cleared. All outputs are 0 except csr_req_ready, which follows the IDLE rule.
- Interrupt enables: en_ext = ext_irq & mie_q[11]; en_tmr = timer_irq & mie_q[7].
- take = mstatus_q[3] & (en_ext | en_tmr).
- Priority in IDLE, highest first: take, mret_valid, wfi_valid, csr_req_valid.
- IDLE + take:
  - Latch epc = ex_pc.
  - Latch cause = 0x8000000B if en_ext, else 0x80000007. External beats timer when both are set.
  - Go to SAVE_EPC. stall=1 in the accept cycle; the pending csr_req is not accepted (csr_req_ready=0).
- SAVE_EPC: csr_we=1, addr 0x341, data epc -> SAVE_CAUSE.
- SAVE_CAUSE: we=1, addr 0x342, data cause -> UPD_STATUS.
- UPD_STATUS: we=1, addr 0x300, data = mstatus_q with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11. Latch target = {mtvec_q[31:2],2'b00} -> REDIRECT.
- IDLE + mret_valid -> MRET_STATUS.
- MRET_STATUS: we=1, addr 0x300, data = mstatus_q with MIE=MPIE, MPIE=1, MPP=2'b11. Latch target = mepc_q -> REDIRECT.
- REDIRECT: redirect_valid=1, redirect_pc=target, stall=1 -> IDLE.
- IDLE + wfi_valid -> WFI_SLEEP.
- WFI_SLEEP: stall=1 until (en_ext|en_tmr), checked independently of MIE.
  - On wake with MIE=1: treat as take with epc = ex_pc+4.
  - On wake with MIE=0: return to IDLE with no redirect; stall drops the next cycle.
- IDLE, no other event: csr_req_ready = 1 and is combinational. When csr_req_valid, pass the request through the same cycle: csr_we=1, waddr=csr_req_addr, wdata=csr_req_wdata.
- stall is combinational: 1 in every non-IDLE state and in the IDLE cycle that accepts take/mret/wfi; otherwise 0.
- Latencies:
  - Trap entry: accept T, writes at T+1/T+2/T+3, redirect at T+4.
  - mret: accept T, write at T+1, redirect at T+2.
- take, mret and wfi are ignored outside IDLE. Interrupt levels are re-sampled only on return to IDLE.
- Arithmetic: ex_pc+4 wraps mod 2^32. No other arithmetic.

Decomposition:
- Shared package csr_pkg:
  - CSR address constants (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342).
  - mstatus bit indices (MIE 3, MPIE 7, MPP 12:11).
  - Cause constants.
  - trap_state_e enum.
- Sub-module: csr_wport_mux. It selects between pipeline and FSM write sources; the FSM drives the select.

Test Plan:
- IDLE, mstatus_q=0x00001808, mie_q=0x800, ext_irq=1, ex_pc=0x100, mtvec_q=0x200 -> writes (0x341,0x100), (0x342,0x8000000B), (0x300,0x00001880) on consecutive cycles; then redirect_valid with redirect_pc 0x200; stall high 5 cycles.
- ext_irq=1 and timer_irq=1, mie_q=0x880, MIE=1 -> mcause written 0x8000000B.
- MIE=0, ext_irq=1, csr_req_valid with addr 0x300, data 0xA -> no trap; csr_req_ready=1; csr_we same cycle with addr 0x300, data 0xA.
- mret_valid, mstatus_q=0x00001880, mepc_q=0x104 -> write (0x300,0x00001888) at T+1; redirect 0x104 at T+2.
- wfi_valid at ex_pc=0x300, MIE=1, timer_irq raised 10 cycles later with MTIE=1 -> stall the whole time; then mepc written 0x304, mcause 0x80000007. Repeat with MIE=0 -> no writes, no redirect, stall drops.
- rst asserted during SAVE_CAUSE -> outputs 0 immediately. After release, state is IDLE and a simultaneous csr_req is accepted.
